// File: rtl/counter_autoreset_param.sv
// ---------------------------------------------------------------------------
// counter_autoreset_param
//
// General-purpose timing / event-count primitive. Counts up or down between 0
// and a runtime limit, advancing once per prescaler tick. When the count hits
// its terminal value it either reloads (continuous mode) or parks in a DONE
// state (one-shot mode). Every terminal event produces a one-cycle wrap pulse.
//
// Parameters:
//   WIDTH       width of value, limit and load_value
//   PRESCALE_W  width of prescale input and internal prescale counter
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   en          count enable; low pauses value and prescaler phase
//   clr         synchronous clear (highest priority)
//   load        synchronous load of load_value (saturated to limit)
//   load_value  value used on load
//   limit       terminal value, sampled live every cycle
//   dir         0 = count up, 1 = count down
//   one_shot    1 = stop at terminal value, 0 = reload and continue
//   prescale    a tick occurs every prescale+1 enabled cycles
//   value       current count (registered)
//   wrap        registered one-cycle pulse per terminal event
//   done        high while parked in DONE
//   busy        combinational: running and enabled
// ---------------------------------------------------------------------------
module counter_autoreset_param #(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  clr,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_value,
  input  logic [WIDTH-1:0]      limit,
  input  logic                  dir,
  input  logic                  one_shot,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [WIDTH-1:0]      value,
  output logic                  wrap,
  output logic                  done,
  output logic                  busy
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [WIDTH-1:0]      r_value;
  logic [WIDTH-1:0]      w_value_nxt;
  logic                  r_wrap;
  logic                  w_wrap_nxt;
  logic [PRESCALE_W-1:0] r_pre_cnt;
  logic [PRESCALE_W-1:0] w_pre_cnt_nxt;

  logic                  w_active;
  logic                  w_tick;
  logic                  w_terminal;
  logic [WIDTH-1:0]      w_load_sat;
  logic [WIDTH-1:0]      w_reload;

  // State register: everything visible on the outputs lives here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_RUN;
      r_value   <= '0;
      r_wrap    <= 1'b0;
      r_pre_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_value   <= w_value_nxt;
      r_wrap    <= w_wrap_nxt;
      r_pre_cnt <= w_pre_cnt_nxt;
    end
  end

  // Only a running, enabled counter advances the prescaler.
  assign w_active = (r_state == ST_RUN) && en;

  // Compare with >= so that shrinking prescale below the current phase
  // fires on the next edge instead of running all the way around.
  assign w_tick = w_active && (r_pre_cnt >= prescale);

  // Up direction uses >= so a limit lowered below value terminates at once
  // rather than counting up through the whole range.
  assign w_terminal = dir ? (r_value == '0) : (r_value >= limit);

  assign w_load_sat = (load_value > limit) ? limit : load_value;
  assign w_reload   = dir ? limit : '0;

  // Next-state logic with priority clr > load > count.
  always_comb begin
    w_state_nxt   = r_state;
    w_value_nxt   = r_value;
    w_wrap_nxt    = 1'b0;
    w_pre_cnt_nxt = r_pre_cnt;

    if (clr) begin
      w_value_nxt   = w_reload;
      w_pre_cnt_nxt = '0;
      w_state_nxt   = ST_RUN;
    end else if (load) begin
      w_value_nxt   = w_load_sat;
      w_pre_cnt_nxt = '0;
      w_state_nxt   = ST_RUN;
    end else if (w_active) begin
      if (w_tick) begin
        w_pre_cnt_nxt = '0;
        if (w_terminal) begin
          w_wrap_nxt = 1'b1;
          if (one_shot) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_value_nxt = w_reload;
          end
        end else if (dir) begin
          w_value_nxt = r_value - 1'b1;
        end else begin
          w_value_nxt = r_value + 1'b1;
        end
      end else begin
        w_pre_cnt_nxt = r_pre_cnt + 1'b1;
      end
    end
  end

  assign value = r_value;
  assign wrap  = r_wrap;
  assign done  = (r_state == ST_DONE);
  assign busy  = w_active;

endmodule

// File: tb/tb_counter_autoreset_param.sv
// ---------------------------------------------------------------------------
// tb_counter_autoreset_param
//
// Directed bench for counter_autoreset_param. An 8-bit instance is driven
// from a table of per-cycle records with hand-computed expected outputs; a
// 16-bit instance covers the full-range wrap, and asynchronous reset is
// exercised by hand-written sequences.
// ---------------------------------------------------------------------------
module tb_counter_autoreset_param;

  typedef struct {
    logic       en;
    logic       clr;
    logic       load;
    logic [7:0] lv;
    logic [7:0] lim;
    logic       dir;
    logic       os;
    logic [3:0] ps;
    logic [7:0] expValue;
    logic       expWrap;
    logic       expDone;
    logic       expBusy;
  } vec_t;

  logic        clk;
  logic        rst;

  logic        en, clr, load, dir, oneShot;
  logic [7:0]  loadValue, limit;
  logic [3:0]  prescale;
  logic [7:0]  value;
  logic        wrap, done, busy;

  logic        en16, clr16, load16, dir16, oneShot16;
  logic [15:0] loadValue16, limit16;
  logic [3:0]  prescale16;
  logic [15:0] value16;
  logic        wrap16, done16, busy16;

  int          total;
  int          bad;
  vec_t        vecs[$];

  counter_autoreset_param #(.WIDTH(8), .PRESCALE_W(4)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load),
    .load_value(loadValue), .limit(limit), .dir(dir), .one_shot(oneShot),
    .prescale(prescale), .value(value), .wrap(wrap), .done(done), .busy(busy)
  );

  counter_autoreset_param #(.WIDTH(16), .PRESCALE_W(4)) dut16 (
    .clk(clk), .rst(rst), .en(en16), .clr(clr16), .load(load16),
    .load_value(loadValue16), .limit(limit16), .dir(dir16),
    .one_shot(oneShot16), .prescale(prescale16), .value(value16),
    .wrap(wrap16), .done(done16), .busy(busy16)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison with FAIL reporting.
  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic addVec(input logic e, input logic c, input logic l,
                        input logic [7:0] lv, input logic [7:0] lim,
                        input logic d, input logic os, input logic [3:0] ps,
                        input logic [7:0] ev, input logic ew,
                        input logic ed, input logic eb);
    vec_t v;
    v.en = e; v.clr = c; v.load = l; v.lv = lv; v.lim = lim; v.dir = d;
    v.os = os; v.ps = ps; v.expValue = ev; v.expWrap = ew; v.expDone = ed;
    v.expBusy = eb;
    vecs.push_back(v);
  endtask

  // Drive one record for one clock edge, then compare just after the edge.
  task automatic applyStimulus(input vec_t v, input int idx);
    en = v.en; clr = v.clr; load = v.load; loadValue = v.lv; limit = v.lim;
    dir = v.dir; oneShot = v.os; prescale = v.ps;
    @(posedge clk);
    #1;
    checkOutput($sformatf("vec%0d.value", idx), {8'h00, value}, {8'h00, v.expValue});
    checkOutput($sformatf("vec%0d.wrap", idx), {15'h0, wrap}, {15'h0, v.expWrap});
    checkOutput($sformatf("vec%0d.done", idx), {15'h0, done}, {15'h0, v.expDone});
    checkOutput($sformatf("vec%0d.busy", idx), {15'h0, busy}, {15'h0, v.expBusy});
  endtask

  // One clock edge for the 16-bit instance, then compare value and wrap.
  task automatic step16(input string name, input logic [15:0] ev, input logic ew);
    @(posedge clk);
    #1;
    checkOutput({name, ".value"}, value16, ev);
    checkOutput({name, ".wrap"}, {15'h0, wrap16}, {15'h0, ew});
  endtask

  initial begin
    total = 0;
    bad   = 0;

    rst = 1'b1;
    en = 0; clr = 0; load = 0; loadValue = 0; limit = 0; dir = 0;
    oneShot = 0; prescale = 0;
    en16 = 0; clr16 = 0; load16 = 0; loadValue16 = 0; limit16 = 0;
    dir16 = 0; oneShot16 = 0; prescale16 = 0;

    // Up, continuous, limit 5: wrap only as value returns to 0.
    for (int i = 0; i < 8; i++) begin
      logic [7:0] ev;
      ev = (i < 5) ? 8'(i + 1) : ((i == 5) ? 8'd0 : 8'(i - 5));
      addVec(1,0,0,8'd0,8'd5,0,0,4'd0, ev, (i == 5), 0, 1);
    end
    // One-shot up to 3, park in DONE, ignore en, leave via clr.
    addVec(1,1,0,8'd0,8'd3,0,1,4'd0, 8'd0,0,0,1);
    addVec(1,0,0,8'd0,8'd3,0,1,4'd0, 8'd1,0,0,1);
    addVec(1,0,0,8'd0,8'd3,0,1,4'd0, 8'd2,0,0,1);
    addVec(1,0,0,8'd0,8'd3,0,1,4'd0, 8'd3,0,0,1);
    addVec(1,0,0,8'd0,8'd3,0,1,4'd0, 8'd3,1,1,0);
    addVec(1,0,0,8'd0,8'd3,0,1,4'd0, 8'd3,0,1,0);
    addVec(0,0,0,8'd0,8'd3,0,1,4'd0, 8'd3,0,1,0);
    addVec(1,0,0,8'd0,8'd3,0,1,4'd0, 8'd3,0,1,0);
    addVec(1,1,0,8'd0,8'd3,0,1,4'd0, 8'd0,0,0,1);
    addVec(1,0,0,8'd0,8'd3,0,1,4'd0, 8'd1,0,0,1);
    // Down, continuous, limit 4 from load 2; then one-shot stops at 0.
    addVec(1,0,1,8'd2,8'd4,1,0,4'd0, 8'd2,0,0,1);
    addVec(1,0,0,8'd0,8'd4,1,0,4'd0, 8'd1,0,0,1);
    addVec(1,0,0,8'd0,8'd4,1,0,4'd0, 8'd0,0,0,1);
    addVec(1,0,0,8'd0,8'd4,1,0,4'd0, 8'd4,1,0,1);
    addVec(1,0,0,8'd0,8'd4,1,0,4'd0, 8'd3,0,0,1);
    addVec(1,0,0,8'd0,8'd4,1,1,4'd0, 8'd2,0,0,1);
    addVec(1,0,0,8'd0,8'd4,1,1,4'd0, 8'd1,0,0,1);
    addVec(1,0,0,8'd0,8'd4,1,1,4'd0, 8'd0,0,0,1);
    addVec(1,0,0,8'd0,8'd4,1,1,4'd0, 8'd0,1,1,0);
    addVec(1,0,0,8'd0,8'd4,1,1,4'd0, 8'd0,0,1,0);
    // Load saturates to limit and exits DONE; clr beats load.
    addVec(1,0,1,8'd9,8'd5,0,0,4'd0, 8'd5,0,0,1);
    addVec(1,1,1,8'd9,8'd5,0,0,4'd0, 8'd0,0,0,1);
    // Prescale 2 with an en pause mid-phase; then prescale lowered below phase.
    addVec(1,1,0,8'd0,8'd255,0,0,4'd2, 8'd0,0,0,1);
    addVec(1,0,0,8'd0,8'd255,0,0,4'd2, 8'd0,0,0,1);
    addVec(1,0,0,8'd0,8'd255,0,0,4'd2, 8'd0,0,0,1);
    addVec(1,0,0,8'd0,8'd255,0,0,4'd2, 8'd1,0,0,1);
    addVec(1,0,0,8'd0,8'd255,0,0,4'd2, 8'd1,0,0,1);
    addVec(0,0,0,8'd0,8'd255,0,0,4'd2, 8'd1,0,0,0);
    addVec(0,0,0,8'd0,8'd255,0,0,4'd2, 8'd1,0,0,0);
    addVec(1,0,0,8'd0,8'd255,0,0,4'd2, 8'd1,0,0,1);
    addVec(1,0,0,8'd0,8'd255,0,0,4'd2, 8'd2,0,0,1);
    addVec(1,0,0,8'd0,8'd255,0,0,4'd2, 8'd2,0,0,1);
    addVec(1,0,0,8'd0,8'd255,0,0,4'd0, 8'd3,0,0,1);
    // Limit lowered below value while counting up.
    addVec(1,0,1,8'd48,8'd200,0,0,4'd0, 8'd48,0,0,1);
    addVec(1,0,0,8'd0,8'd200,0,0,4'd0, 8'd49,0,0,1);
    addVec(1,0,0,8'd0,8'd200,0,0,4'd0, 8'd50,0,0,1);
    addVec(1,0,0,8'd0,8'd10,0,0,4'd0, 8'd0,1,0,1);
    addVec(1,0,0,8'd0,8'd10,0,0,4'd0, 8'd1,0,0,1);
    // Limit 0: every tick is terminal.
    addVec(1,1,0,8'd0,8'd0,0,0,4'd0, 8'd0,0,0,1);
    addVec(1,0,0,8'd0,8'd0,0,0,4'd0, 8'd0,1,0,1);
    addVec(1,0,0,8'd0,8'd0,0,0,4'd0, 8'd0,1,0,1);

    // Reset values, observed while reset is still held.
    #2;
    checkOutput("reset.value", {8'h00, value}, 16'h0000);
    checkOutput("reset.wrap", {15'h0, wrap}, 16'h0000);
    checkOutput("reset.done", {15'h0, done}, 16'h0000);
    checkOutput("reset.value16", value16, 16'h0000);
    @(posedge clk);
    #3;
    rst = 1'b0;

    foreach (vecs[i]) applyStimulus(vecs[i], i);

    // Asynchronous reset mid-cycle clears value without an edge.
    en = 1; clr = 0; load = 0; limit = 8'd100; dir = 0; oneShot = 0;
    prescale = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
    end
    #1;
    checkOutput("prerst.value", {8'h00, value}, 16'h0003);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("midrst.value", {8'h00, value}, 16'h0000);
    en = 0;
    #3;
    rst = 1'b0;

    // Asynchronous reset clears done and a pending wrap pulse.
    en = 1; limit = 8'd0; oneShot = 1;
    @(posedge clk);
    #1;
    checkOutput("os0.wrap", {15'h0, wrap}, 16'h0001);
    checkOutput("os0.done", {15'h0, done}, 16'h0001);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("midrst.wrap", {15'h0, wrap}, 16'h0000);
    checkOutput("midrst.done", {15'h0, done}, 16'h0000);
    en = 0;
    #3;
    rst = 1'b0;

    // 16-bit full-range wrap: FFFD -> FFFE -> FFFF -> 0 with wrap.
    en16 = 1; load16 = 1; loadValue16 = 16'hFFFD; limit16 = 16'hFFFF;
    step16("w16.load", 16'hFFFD, 1'b0);
    load16 = 0;
    step16("w16.c1", 16'hFFFE, 1'b0);
    step16("w16.c2", 16'hFFFF, 1'b0);
    step16("w16.c3", 16'h0000, 1'b1);
    step16("w16.c4", 16'h0001, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/counter_autoreset_param.md
Name: counter_autoreset_param

Overview:
Parametrised next-generation autoreset counter with runtime limit, up/down direction, prescaler, synchronous load/clear and one-shot vs continuous mode. It produces a registered count, a single-cycle wrap pulse and a done flag. It is used as the general timing and event-count primitive in lab datapaths, replacing fixed 8-bit counters.

Parameters:
WIDTH, 8, width of count, limit and load value.
PRESCALE_W, 4, width of prescale input and of the internal prescale counter.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
en  in  1  count enable; low = pause, with value and prescaler phase held.
clr  in  1  synchronous clear.
load  in  1  synchronous load of load_value.
load_value  in  WIDTH  value used on load.
limit  in  WIDTH  terminal value, sampled live every cycle.
dir  in  1  0 = count up, 1 = count down.
one_shot  in  1  1 = stop at the terminal value, 0 = continuous wrap/reload.
prescale  in  PRESCALE_W  a count tick occurs every prescale+1 enabled cycles.
value  out  WIDTH  current count, registered.
wrap  out  1  registered pulse, one cycle per terminal event.
done  out  1  high while in the DONE state.
busy  out  1  combinational: state==RUN and en==1.

Behaviour:
- Reset (rst=1, asynchronous, takes effect without a clock edge): value=0, wrap=0, done=0, pre_cnt=0, state=RUN.
- States:
  - RUN: counts.
  - DONE: one-shot terminal was reached. Value is frozen, en is ignored, done=1.
- Per-edge priority: clr > load > count.
- clr:
  - value <= (dir ? limit : 0).
  - pre_cnt <= 0, state <= RUN, wrap <= 0.
- load:
  - value <= min(load_value, limit); a load_value above limit saturates to limit.
  - pre_cnt <= 0, state <= RUN, wrap <= 0.
- Prescaler (RUN with en=1 only):
  - If pre_cnt==prescale: tick=1 and pre_cnt <= 0.
  - Otherwise pre_cnt <= pre_cnt+1.
  - prescale=0 gives a tick every enabled cycle.
  - If prescale is changed so that it is below pre_cnt, the next edge treats it as a match (compare uses >=).
- Tick, up direction:
  - If value >= limit, a terminal event occurs.
  - Otherwise value <= value+1.
- Tick, down direction:
  - If value==0, a terminal event occurs.
  - Otherwise value <= value-1.
- Terminal event:
  - wrap <= 1 for exactly one cycle. It is visible in the same cycle as the post-terminal value.
  - Continuous mode: value <= 0 (up) or value <= limit (down).
  - One-shot mode: value holds its current value (limit or 0), state <= DONE.
- wrap is 0 on every edge without a terminal event.
- Limit lowered below value while counting up: the next tick is a terminal event (no runaway). Between ticks, value is not modified.
- limit=0: every tick is terminal; value stays 0 and wrap pulses once per tick.
- dir or one_shot changed mid-count: takes effect on the next tick, with no extra event.
- Arithmetic is modulo 2^WIDTH, but overflow cannot occur because the terminal check precedes the increment. Maximum span is limit = 2^WIDTH-1.
- en=0 in RUN: value, pre_cnt and state hold; wrap=0.
- DONE is exited only via clr, load or rst. While in DONE, done=1 and busy=0.
- Latency: with prescale=0, value changes on the first rising edge at which en=1.

Test Plan:
1. WIDTH=8, limit=5, prescale=0, up, continuous, en=1 -> value 0,1,2,3,4,5,0,1; wrap=1 only in the cycle where value returns to 0. Assert rst mid-cycle -> value=0 immediately, before the next edge.
2. prescale=2, limit=255, en=1 -> value steps every 3 cycles. Drop en for 2 cycles mid-phase -> value and phase held; count resumes with no lost or extra tick; busy follows en.
3. one_shot=1, up, limit=3 -> 0,1,2,3; next tick gives wrap pulse, done=1, value stays 3. Toggle en -> no change. Assert clr -> value=0, done=0, counting resumes.
4. dir=1, continuous, limit=4, load load_value=2 -> 2,1,0,4,3; wrap at the 0->4 reload. With one_shot=1 -> stops at 0 with done=1.
5. Load load_value=9 with limit=5 -> value=5. clr and load asserted in the same cycle, dir=0 -> value=0 (clr wins).
6. Count up to value=50 with limit=200, then set limit=10 -> next tick gives wrap, value=0. WIDTH=16, limit=16'hFFFF -> reaches FFFF, then wraps to 0 with no overflow glitch.
